alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU with valid/ready handshakes on both input and output.
- Same 16-operation opcode map as the team's combinational 8-bit ALU, generalised to WIDTH bits.
- Adds status flags, a divide-by-zero error, backpressure and a completed-operation counter.
- Sits between an operand issue stage (upstream) and a writeback/consumer stage (downstream).

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 64).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block accepts a bundle this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  4  operation select.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  result.
- out_flags  output  4  {N, V, C, Z}: negative, signed overflow, carry/borrow/shift-out, zero.
- out_dz  output  1  divide-by-zero error for this result.
- op_count  output  CNT_W  number of results accepted downstream.

Behaviour:
- Reset: asynchronous, active-high. All pipeline valids, out_result, out_flags, out_dz and op_count clear to 0. in_ready is 1 out of reset.
- Reset mid-operation: all in-flight bundles are discarded; no partial result is ever presented.
- Stage S1 registers {a, b, op}.
- Stage S2 computes the result and registers {result, flags, dz}. S2 drives the out_* ports.
- S2 advances when !s2_valid or out_ready.
- S1 advances when !s1_valid or S2 advances.
- in_ready equals the S1 advance condition. This is a combinational path from out_ready and is permitted.
- Accept occurs on in_valid & in_ready. Result transfer occurs on out_valid & out_ready.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 per cycle when out_ready is held high.
- Bubbles collapse.
- While out_valid & !out_ready, out_result, out_flags and out_dz hold stable.
- Opcodes (all results truncated to WIDTH bits):
  - 0 ADD a+b; C = carry out; V = signed overflow.
  - 1 SUB a-b; C = borrow (a<b unsigned); V = signed overflow.
  - 2 MUL low WIDTH bits of a*b; C = 1 if the upper WIDTH bits of the product are nonzero.
  - 3 DIV unsigned a/b. If b==0: result 0, out_dz=1.
  - 4 SHL a<<1; C = a[MSB].
  - 5 SHR a>>1 (logical); C = a[0].
  - 6 ROL, 7 ROR by one bit.
  - 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR.
  - E GT: result 1 if a>b unsigned, else 0.
  - F EQ: result 1 if a==b, else 0.
- Flags:
  - C and V are 0 for every opcode not listed above.
  - Z = (result==0), for all ops.
  - N = result[WIDTH-1], for all ops.
  - out_dz is 0 for every op except DIV with b==0.
- op_count increments by 1 on each result transfer and wraps from 2^CNT_W-1 to 0.
- Simultaneous accept and transfer in the same cycle is legal and does not lose or duplicate a bundle.

Test Plan:
- Reset then single ADD, a=8'hF0, b=8'h20, out_ready=1 -> out_valid 2 cycles after accept, result 8'h10, C=1, Z=0, op_count=1.
- Back-to-back stream of SUB 5-7, MUL 8'h10*8'h10, DIV 9/0 with out_ready=1 -> results in order, 1 per cycle:
  - 8'hFE with C=1, N=1;
  - 8'h00 with C=1, Z=1;
  - 8'h00 with out_dz=1.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after 2 accepts; out_result stable; release out_ready -> no loss or duplication; op_count equals number sent.
- Signed overflow: ADD 8'h7F+8'h01 -> result 8'h80, V=1, N=1. SUB 8'h80-8'h01 -> result 8'h7F, V=1.
- Shifts/rotates/compare: a=8'h81 -> SHL 8'h02 C=1; SHR 8'h40 C=1; ROL 8'h03; ROR 8'hC0. GT 3>2 -> 1; EQ 3==2 -> 0 with Z=1.
- Assert rst with 2 bundles in flight -> out_valid=0 immediately, op_count=0, no stale result after release. Repeat ADD with WIDTH=16: 16'hFFFF+1 -> 0, C=1, Z=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers the operands; S2 computes and holds the result/flags.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_dz,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV,
        OP_SHL, OP_SHR, OP_ROL, OP_ROR,
        OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_NAND, OP_XNOR, OP_GT, OP_EQ
    } op_e;

    localparam int W = WIDTH;

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    op_e          s1_op;
    logic         s2_valid;
    logic         s1_adv;
    logic         s2_adv;

    logic [W:0]     sum;
    logic [W:0]     dif;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   res;
    logic           c;
    logic           v;
    logic           dz;
    logic           msb;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    assign msb  = s1_a[W-1];
    assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
    assign dif  = {1'b0, s1_a} - {1'b0, s1_b};
    assign prod = {{W{1'b0}}, s1_a} * {{W{1'b0}}, s1_b};
    assign quo  = (s1_b == '0) ? '0 : s1_a / s1_b;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        dz  = 1'b0;
        unique case (s1_op)
            OP_ADD: begin
                res = sum[W-1:0];
                c   = sum[W];
                v   = (msb == s1_b[W-1]) && (res[W-1] != msb);
            end
            OP_SUB: begin
                res = dif[W-1:0];
                c   = dif[W];
                v   = (msb != s1_b[W-1]) && (res[W-1] != msb);
            end
            OP_MUL: begin
                res = prod[W-1:0];
                c   = |prod[2*W-1:W];
            end
            OP_DIV: begin
                res = quo;
                dz  = (s1_b == '0);
            end
            OP_SHL: begin
                res = {s1_a[W-2:0], 1'b0};
                c   = msb;
            end
            OP_SHR: begin
                res = {1'b0, s1_a[W-1:1]};
                c   = s1_a[0];
            end
            OP_ROL:  res = {s1_a[W-2:0], msb};
            OP_ROR:  res = {s1_a[0], s1_a[W-1:1]};
            OP_AND:  res = s1_a & s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_NOR:  res = ~(s1_a | s1_b);
            OP_NAND: res = ~(s1_a & s1_b);
            OP_XNOR: res = ~(s1_a ^ s1_b);
            OP_GT:   res = {{(W-1){1'b0}}, s1_a > s1_b};
            OP_EQ:   res = {{(W-1){1'b0}}, s1_a == s1_b};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= op_e'(in_op);
            end
        end
    end

    // S2 only reloads when it advances, so a stalled result holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            out_dz     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res;
                out_flags  <= {res[W-1], v, c, res == '0};
                out_dz     <= dz;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (s2_valid && out_ready) begin
            op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed steps feed a scoreboard queue that a
// negedge monitor drains on every result transfer.
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] r;
        logic [3:0] f;
        logic       dz;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic [3:0]  out_flags;
    logic        out_dz;
    logic [15:0] op_count;

    logic        v16;
    logic        rdy16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [3:0]  op16;
    logic        ov16;
    logic        ordy16;
    logic [15:0] res16;
    logic [3:0]  fl16;
    logic        dz16;
    logic [15:0] cnt16;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          nsent = 0;
    logic [15:0] exp_cnt = '0;
    ent_t        sb[$];
    logic        held_v = 1'b0;
    ent_t        held;
    logic        rnd_ready = 1'b0;

    alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .out_dz(out_dz), .op_count(op_count)
    );

    alu_pipe #(.WIDTH(16), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(v16), .in_ready(rdy16),
        .in_a(a16), .in_b(b16), .in_op(op16),
        .out_valid(ov16), .out_ready(ordy16),
        .out_result(res16), .out_flags(fl16),
        .out_dz(dz16), .op_count(cnt16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(logic [7:0] r, logic v, logic c, logic dz);
        ent_t e;
        e.r  = r;
        e.f  = {r[7], v, c, r == 8'h00};
        e.dz = dz;
        return e;
    endfunction

    // Reference model written with integer arithmetic.
    function automatic ent_t model(logic [7:0] a, logic [7:0] b,
                                   logic [3:0] op);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sbv = $signed(b);
        int full = 0;
        int s = 0;
        logic [7:0] r = 8'h00;
        logic c = 1'b0;
        logic v = 1'b0;
        logic dz = 1'b0;
        case (op)
            4'h0: begin
                full = ua + ub; r = full[7:0]; c = full > 255;
                s = sa + sbv; v = (s > 127) || (s < -128);
            end
            4'h1: begin
                full = ua - ub; r = full[7:0]; c = ua < ub;
                s = sa - sbv; v = (s > 127) || (s < -128);
            end
            4'h2: begin
                full = ua * ub; r = full[7:0]; c = full > 255;
            end
            4'h3: begin
                if (ub == 0) dz = 1'b1;
                else begin full = ua / ub; r = full[7:0]; end
            end
            4'h4: begin full = ua * 2; r = full[7:0]; c = ua >= 128; end
            4'h5: begin full = ua / 2; r = full[7:0]; c = (ua % 2) == 1; end
            4'h6: begin full = ua * 2 + ua / 128; r = full[7:0]; end
            4'h7: begin full = ua / 2 + (ua % 2) * 128; r = full[7:0]; end
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = ~(a | b);
            4'hC: r = ~(a & b);
            4'hD: r = ~(a ^ b);
            4'hE: r = (ua > ub) ? 8'd1 : 8'd0;
            default: r = (ua == ub) ? 8'd1 : 8'd0;
        endcase
        return mk(r, v, c, dz);
    endfunction

    function automatic void push(ent_t e);
        sb.push_back(e);
        nsent++;
    endfunction

    task automatic send(logic [7:0] a, logic [7:0] b, logic [3:0] op,
                        ent_t e);
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        for (int k = 0; k < 60; k++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                push(e);
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            sb.delete();
            exp_cnt = '0;
            held_v = 1'b0;
        end else begin
            chk("op_count", op_count, exp_cnt);
            if (held_v && out_valid)
                chk("stall_hold", {out_result, out_flags, out_dz}, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", out_result, e.r);
                    chk("flags", out_flags, e.f);
                    chk("dz", out_dz, e.dz);
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            held_v = out_valid && !out_ready;
            held = {out_result, out_flags, out_dz};
        end
    end

    initial begin
        logic acc;
        int nacc;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b1;
        v16 = 1'b0;
        a16 = '0;
        b16 = '0;
        op16 = '0;
        ordy16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", out_result, 0);
        chk("rst_flags", out_flags, 0);
        chk("rst_dz", out_dz, 0);
        chk("rst_count", op_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single ADD with latency check.
        send(8'hF0, 8'h20, 4'h0, mk(8'h10, 1'b0, 1'b1, 1'b0));
        acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) begin acc = 1'b1; break; end
        end
        chk("add_seen", acc, 1);
        chk("latency", cyc - last_acc, 2);
        drain();
        chk("count_one", op_count, 1);

        // Back-to-back stream.
        send(8'h05, 8'h07, 4'h1, mk(8'hFE, 1'b0, 1'b1, 1'b0));
        send(8'h10, 8'h10, 4'h2, mk(8'h00, 1'b0, 1'b1, 1'b0));
        send(8'h09, 8'h00, 4'h3, mk(8'h00, 1'b0, 1'b0, 1'b1));
        drain();

        // Overflow, shifts, rotates, compares.
        send(8'h7F, 8'h01, 4'h0, mk(8'h80, 1'b1, 1'b0, 1'b0));
        send(8'h80, 8'h01, 4'h1, mk(8'h7F, 1'b1, 1'b0, 1'b0));
        send(8'h81, 8'h00, 4'h4, mk(8'h02, 1'b0, 1'b1, 1'b0));
        send(8'h81, 8'h00, 4'h5, mk(8'h40, 1'b0, 1'b1, 1'b0));
        send(8'h81, 8'h00, 4'h6, mk(8'h03, 1'b0, 1'b0, 1'b0));
        send(8'h81, 8'h00, 4'h7, mk(8'hC0, 1'b0, 1'b0, 1'b0));
        send(8'h03, 8'h02, 4'hE, mk(8'h01, 1'b0, 1'b0, 1'b0));
        send(8'h03, 8'h02, 4'hF, mk(8'h00, 1'b0, 1'b0, 1'b0));
        drain();

        // Backpressure: only two bundles fit while output is stalled.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'h11;
        in_b = 8'h22;
        in_op = 4'hA;
        nacc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                push(model(in_a, in_b, in_op));
                nacc++;
            end
            @(posedge clk);
            #1;
            if (acc) in_a = in_a + 8'h13;
        end
        chk("bp_accepts", nacc, 2);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("bp_count", op_count, nsent);

        // Random stream with random backpressure.
        rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [3:0] ro;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ro = 4'($urandom_range(0, 15));
            if (k % 9 == 0) rb = 8'h00;
            send(ra, rb, ro, model(ra, rb, ro));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rnd_count", op_count, nsent);

        // Reset with two bundles in flight.
        out_ready = 1'b0;
        send(8'h01, 8'h02, 4'h0, mk(8'h03, 1'b0, 1'b0, 1'b0));
        send(8'h03, 8'h04, 4'h0, mk(8'h07, 1'b0, 1'b0, 1'b0));
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", op_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nsent = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end

        // 16-bit instance: carry out of the full width.
        @(posedge clk);
        #1;
        v16 = 1'b1;
        a16 = 16'hFFFF;
        b16 = 16'h0001;
        op16 = 4'h0;
        @(negedge clk);
        chk("w16_in_ready", rdy16, 1);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov16) begin acc = 1'b1; break; end
        end
        chk("w16_seen", acc, 1);
        chk("w16_result", res16, 16'h0000);
        chk("w16_flags", fl16, 4'b0011);
        chk("w16_dz", dz16, 0);
        @(posedge clk);
        #1;
        chk("w16_count", cnt16, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
